// File: rtl/sram_arbiter.sv
// sram_arbiter
//
// Shares one single-transaction SRAM controller between two bus masters
// (typically the CPU bridge on port 0 and a video/DMA fetcher on port 1).
// Requests are level-held; the winning request's command, address and write
// data are latched at grant so the requester is free to change them while
// the access is in flight. The controller is driven with one-cycle
// read/write strobes, the arbiter waits for it to go busy and come back
// to idle, then returns a one-cycle acknowledge (with read data on reads).
//
// Parameters
//   ADDR_WIDTH  word address width (matches the controller)
//   DATA_WIDTH  data word width
//   FIXED_PRIO  0 = round-robin between the ports, 1 = port 0 always wins
//
// Ports
//   clk, reset_n          clock; asynchronous active-low reset
//   pN_req                port N request, level, held until pN_ack
//   pN_we                 port N direction, 1 = write
//   pN_addr, pN_wdata     port N address / write data
//   pN_rdata              port N read data, valid with pN_ack, held until
//                         the next read acknowledge on that port
//   pN_ack                port N one-cycle completion pulse
//   sram_read/write       one-cycle strobes to the controller
//   sram_address          latched address to the controller
//   sram_data_write       latched write data to the controller
//   sram_data_read        controller read result
//   sram_ready            controller idle flag
//   busy                  high whenever the arbiter is not idle
//   owner                 port of the current or most recent grant
module sram_arbiter #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_ack,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_ack,

    output logic                  sram_read,
    output logic                  sram_write,
    output logic [ADDR_WIDTH-1:0] sram_address,
    output logic [DATA_WIDTH-1:0] sram_data_write,
    input  logic [DATA_WIDTH-1:0] sram_data_read,
    input  logic                  sram_ready,

    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t                  state_q, state_nxt;
    logic                    owner_q, owner_nxt;
    logic                    last_grant_q, last_grant_nxt;
    logic                    we_q, we_nxt;
    logic                    seen_busy_q, seen_busy_nxt;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_nxt;
    logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_nxt;
    logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_nxt;

    logic                    any_req;
    logic                    winner;

    // Winner selection. With a single requester it simply wins; under
    // contention round-robin favours the port that was not granted last.
    always_comb begin
        any_req = p0_req | p1_req;
        if (p0_req && p1_req) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end else begin
            winner = p1_req;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt      = state_q;
        owner_nxt      = owner_q;
        last_grant_nxt = last_grant_q;
        we_nxt         = we_q;
        seen_busy_nxt  = seen_busy_q;
        addr_nxt       = addr_q;
        wdata_nxt      = wdata_q;
        rdata0_nxt     = rdata0_q;
        rdata1_nxt     = rdata1_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_nxt      = winner;
                    last_grant_nxt = winner;
                    we_nxt         = winner ? p1_we    : p0_we;
                    addr_nxt       = winner ? p1_addr  : p0_addr;
                    wdata_nxt      = winner ? p1_wdata : p0_wdata;
                    state_nxt      = ISSUE;
                end
            end

            ISSUE: begin
                // The strobe fires combinationally in the cycle the
                // controller reports idle; otherwise just hold.
                if (sram_ready) begin
                    seen_busy_nxt = 1'b0;
                    state_nxt     = WAIT;
                end
            end

            WAIT: begin
                // sram_ready is still high in the cycle after the strobe,
                // so completion only counts once the controller has been
                // seen busy.
                if (!sram_ready) begin
                    seen_busy_nxt = 1'b1;
                end else if (seen_busy_q) begin
                    if (!we_q) begin
                        if (owner_q) begin
                            rdata1_nxt = sram_data_read;
                        end else begin
                            rdata0_nxt = sram_data_read;
                        end
                    end
                    state_nxt = ACK;
                end
            end

            ACK: begin
                // No arbitration here: the requester gets one cycle to drop
                // or update its request before IDLE samples it again.
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            seen_busy_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_nxt;
            owner_q      <= owner_nxt;
            last_grant_q <= last_grant_nxt;
            we_q         <= we_nxt;
            seen_busy_q  <= seen_busy_nxt;
            addr_q       <= addr_nxt;
            wdata_q      <= wdata_nxt;
            rdata0_q     <= rdata0_nxt;
            rdata1_q     <= rdata1_nxt;
        end
    end

    // Outputs are decoded from registered state so they all drop to zero
    // the moment reset is asserted.
    assign sram_read       = (state_q == ISSUE) && sram_ready && !we_q;
    assign sram_write      = (state_q == ISSUE) && sram_ready &&  we_q;
    assign sram_address    = addr_q;
    assign sram_data_write = wdata_q;
    assign p0_ack          = (state_q == ACK) && !owner_q;
    assign p1_ack          = (state_q == ACK) &&  owner_q;
    assign p0_rdata        = rdata0_q;
    assign p1_rdata        = rdata1_q;
    assign busy            = (state_q != IDLE);
    assign owner           = owner_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: instance 0 runs round-robin, instance 1 runs
// fixed priority. Both share a behavioural SRAM controller model (2 busy
// cycles per access). Expected acknowledges are queued by the stimulus and
// consumed by a monitor that fires on every DUT acknowledge.
module tb_sram_arbiter;

    localparam int AW = 18;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;

    logic [1:0] p0_req = '0, p0_we = '0, p1_req = '0, p1_we = '0;
    logic [1:0] p0_ack, p1_ack, s_rd, s_wr, busy, owner;
    logic [1:0] s_ready;
    logic [AW-1:0] p0_addr [2];
    logic [AW-1:0] p1_addr [2];
    logic [AW-1:0] s_addr [2];
    logic [DW-1:0] p0_wdata [2];
    logic [DW-1:0] p1_wdata [2];
    logic [DW-1:0] p0_rdata [2];
    logic [DW-1:0] p1_rdata [2];
    logic [DW-1:0] s_wdata [2];
    logic [DW-1:0] s_rdata [2];

    sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req[0]), .p0_we(p0_we[0]), .p0_addr(p0_addr[0]), .p0_wdata(p0_wdata[0]),
        .p0_rdata(p0_rdata[0]), .p0_ack(p0_ack[0]),
        .p1_req(p1_req[0]), .p1_we(p1_we[0]), .p1_addr(p1_addr[0]), .p1_wdata(p1_wdata[0]),
        .p1_rdata(p1_rdata[0]), .p1_ack(p1_ack[0]),
        .sram_read(s_rd[0]), .sram_write(s_wr[0]), .sram_address(s_addr[0]),
        .sram_data_write(s_wdata[0]), .sram_data_read(s_rdata[0]), .sram_ready(s_ready[0]),
        .busy(busy[0]), .owner(owner[0])
    );

    sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req[1]), .p0_we(p0_we[1]), .p0_addr(p0_addr[1]), .p0_wdata(p0_wdata[1]),
        .p0_rdata(p0_rdata[1]), .p0_ack(p0_ack[1]),
        .p1_req(p1_req[1]), .p1_we(p1_we[1]), .p1_addr(p1_addr[1]), .p1_wdata(p1_wdata[1]),
        .p1_rdata(p1_rdata[1]), .p1_ack(p1_ack[1]),
        .sram_read(s_rd[1]), .sram_write(s_wr[1]), .sram_address(s_addr[1]),
        .sram_data_write(s_wdata[1]), .sram_data_read(s_rdata[1]), .sram_ready(s_ready[1]),
        .busy(busy[1]), .owner(owner[1])
    );

    // ---------------- SRAM controller model ----------------
    // Memory indexed by addr[9:0]; reset contents are i ^ 16'hA5A5 with
    // 0x123 preloaded to 16'hBEEF.
    logic [DW-1:0] mem [1024];
    int            cnt [2];
    logic          pend_we [2];
    logic [9:0]    pend_addr [2];
    logic [DW-1:0] pend_data [2];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= DW'(i) ^ 16'hA5A5;
            mem[10'h123] <= 16'hBEEF;
            for (int k = 0; k < 2; k++) begin
                s_ready[k] <= 1'b1;
                cnt[k]     <= 0;
                s_rdata[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (s_rd[k] || s_wr[k]) begin
                    pend_we[k]   <= s_wr[k];
                    pend_addr[k] <= s_addr[k][9:0];
                    pend_data[k] <= s_wdata[k];
                    s_ready[k]   <= 1'b0;
                    cnt[k]       <= 2;
                end else if (cnt[k] != 0) begin
                    cnt[k] <= cnt[k] - 1;
                    if (cnt[k] == 1) begin
                        s_ready[k] <= 1'b1;
                        if (pend_we[k]) mem[pend_addr[k]] <= pend_data[k];
                        else            s_rdata[k] <= mem[pend_addr[k]];
                    end
                end
            end
        end
    end

    // ---------------- bookkeeping ----------------
    int cyc = 0, rd_cnt = 0, wr_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (s_rd[0]) rd_cnt <= rd_cnt + 1;
        if (s_wr[0]) wr_cnt <= wr_cnt + 1;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic          port;
        logic          rd;
        logic [DW-1:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   ack_cyc0[$];

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (s_rd[k] && s_wr[k]) check("dual strobe", 1, 0);
            if (p0_ack[k] || p1_ack[k]) begin
                exp_t e;
                bit   have;
                logic [DW-1:0] got;
                have = 1'b0;
                if (k == 0) ack_cyc0.push_back(cyc);
                if (p0_ack[k] && p1_ack[k]) check("dual ack", 1, 0);
                if (k == 0) begin
                    if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                end else begin
                    if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                end
                if (!have) begin
                    check($sformatf("unexpected ack inst%0d", k), 1, 0);
                end else begin
                    check($sformatf("ack port inst%0d", k), {31'd0, p1_ack[k]}, {31'd0, e.port});
                    if (e.rd) begin
                        got = e.port ? p1_rdata[k] : p0_rdata[k];
                        check($sformatf("rdata inst%0d port%0d", k, e.port), {16'd0, got}, {16'd0, e.data});
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int k, int port, logic req, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
        if (port == 0) begin
            p0_req[k] = req; p0_we[k] = we; p0_addr[k] = a; p0_wdata[k] = d;
        end else begin
            p1_req[k] = req; p1_we[k] = we; p1_addr[k] = a; p1_wdata[k] = d;
        end
    endtask

    task automatic wait_ack(int k, int port, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick();
            if (port == 0 ? p0_ack[k] : p1_ack[k]) ok = 1'b1;
        end
    endtask

    // Issues n reads at base, base+1, ... keeping req high across acks.
    task automatic requester(int k, int port, int n, logic [AW-1:0] base);
        bit ok;
        for (int i = 0; i < n; i++) begin
            drive(k, port, 1'b1, 1'b0, base + AW'(i), '0);
            wait_ack(k, port, ok);
            check($sformatf("ack timeout inst%0d port%0d", k, port), {31'd0, ok}, 1);
        end
        drive(k, port, 1'b0, 1'b0, base, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int c0, r0, w0, sz;

        for (int k = 0; k < 2; k++) begin
            drive(k, 0, 1'b0, 1'b0, '0, '0);
            drive(k, 1, 1'b0, 1'b0, '0, '0);
        end
        tick(); tick(); tick();

        // Reset state
        check("reset busy/owner", {28'd0, busy, owner}, 0);
        check("reset acks/strobes", {24'd0, p0_ack, p1_ack, s_rd, s_wr}, 0);
        check("reset sram_address", s_addr[0], 0);
        check("reset rdata", {p0_rdata[0], p1_rdata[0]}, 0);

        reset_n = 1'b1;
        tick();

        // Single read from port 0
        q0.push_back('{port: 1'b0, rd: 1'b1, data: 16'hBEEF});
        drive(0, 0, 1'b1, 1'b0, 18'h00123, '0);
        c0 = cyc; r0 = rd_cnt;
        tick();
        check("read strobe cycle1", {31'd0, s_rd[0]}, 1);
        check("busy cycle1", {31'd0, busy[0]}, 1);
        tick();
        check("read strobe cycle2", {31'd0, s_rd[0]}, 0);
        wait_ack(0, 0, ok);
        check("single read ack", {31'd0, ok}, 1);
        check("req-to-ack latency", cyc - c0, 5);
        check("owner after p0", {31'd0, owner[0]}, 0);
        drive(0, 0, 1'b0, 1'b0, 18'h00123, '0);
        tick();
        check("read strobe count", rd_cnt - r0, 1);

        // Port 1 write then read back
        q0.push_back('{port: 1'b1, rd: 1'b0, data: 16'h0000});
        w0 = wr_cnt;
        drive(0, 1, 1'b1, 1'b1, 18'h3FFFF, 16'h5A5A);
        wait_ack(0, 1, ok);
        check("write ack", {31'd0, ok}, 1);
        check("owner after p1", {31'd0, owner[0]}, 1);
        drive(0, 1, 1'b0, 1'b0, 18'h3FFFF, '0);
        tick();
        check("write strobe count", wr_cnt - w0, 1);
        check("p1 rdata untouched by write", p1_rdata[0], 0);

        q0.push_back('{port: 1'b1, rd: 1'b1, data: 16'h5A5A});
        drive(0, 1, 1'b1, 1'b0, 18'h3FFFF, '0);
        wait_ack(0, 1, ok);
        check("readback ack", {31'd0, ok}, 1);
        drive(0, 1, 1'b0, 1'b0, 18'h3FFFF, '0);
        tick();
        check("p0 rdata untouched", p0_rdata[0], 32'hBEEF);

        // Round-robin contention: 0,1,0,1 with acks 6 cycles apart
        q0.push_back('{port: 1'b0, rd: 1'b1, data: 16'hA5E5});
        q0.push_back('{port: 1'b1, rd: 1'b1, data: 16'hA525});
        q0.push_back('{port: 1'b0, rd: 1'b1, data: 16'hA5E4});
        q0.push_back('{port: 1'b1, rd: 1'b1, data: 16'hA524});
        sz = ack_cyc0.size();
        fork
            requester(0, 0, 2, 18'h00040);
            requester(0, 1, 2, 18'h00080);
        join
        tick();
        check("rr ack count", ack_cyc0.size() - sz, 4);
        if (ack_cyc0.size() - sz == 4) begin
            for (int i = 1; i < 4; i++)
                check($sformatf("rr ack spacing %0d", i), ack_cyc0[sz+i] - ack_cyc0[sz+i-1], 6);
        end

        // Request changes after grant are ignored
        q0.push_back('{port: 1'b0, rd: 1'b1, data: 16'hA5B5});
        drive(0, 0, 1'b1, 1'b0, 18'h00010, '0);
        tick();
        tick();
        drive(0, 0, 1'b1, 1'b0, 18'h00020, '0);
        tick();
        check("latched sram_address", s_addr[0], 32'h00010);
        wait_ack(0, 0, ok);
        check("addr-change ack", {31'd0, ok}, 1);
        drive(0, 0, 1'b0, 1'b0, 18'h00020, '0);
        tick();

        // Reset in WAIT: outputs clear at once, no ack for the aborted access
        drive(0, 0, 1'b1, 1'b0, 18'h00020, '0);
        tick();
        tick();
        check("busy before reset", {31'd0, busy[0]}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset busy", {31'd0, busy[0]}, 0);
        check("async reset sram_address", s_addr[0], 0);
        check("async reset rdata", {p0_rdata[0], p1_rdata[0]}, 0);
        check("async reset strobes/acks", {28'd0, s_rd[0], s_wr[0], p0_ack[0], p1_ack[0]}, 0);
        drive(0, 0, 1'b0, 1'b0, '0, '0);
        tick(); tick(); tick();
        reset_n = 1'b1;
        tick();

        // First contention after reset goes to port 0
        q0.push_back('{port: 1'b0, rd: 1'b1, data: 16'hA595});
        q0.push_back('{port: 1'b1, rd: 1'b1, data: 16'hA535});
        fork
            requester(0, 0, 1, 18'h00030);
            requester(0, 1, 1, 18'h00090);
        join
        tick();

        // Fixed priority: port 1 only after port 0 stops requesting
        q1.push_back('{port: 1'b0, rd: 1'b1, data: 16'hA5F5});
        q1.push_back('{port: 1'b0, rd: 1'b1, data: 16'hA5F4});
        q1.push_back('{port: 1'b0, rd: 1'b1, data: 16'hA5F7});
        q1.push_back('{port: 1'b1, rd: 1'b1, data: 16'hA5C5});
        fork
            requester(1, 0, 3, 18'h00050);
            requester(1, 1, 1, 18'h00060);
        join
        tick(); tick();

        check("inst0 expectations drained", q0.size(), 0);
        check("inst1 expectations drained", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got %0d expected completion", n_total);
        $fatal(1);
    end

endmodule
